// File: rtl/fetch_controller.sv
// fetch_controller -- single-outstanding-request instruction fetch sequencer.
// Issues one memory request at a time, holds the returned instruction until
// the core consumes it, and handles redirects, including a redirect that
// arrives while a request is still waiting on memory (drained to completion
// and its data discarded).
// Optional build macro: FETCH_MISALIGN_CHECK_EN -- when defined, a redirect
// to a non-word-aligned target raises sticky misalign_err and parks the
// controller in ERROR until reset. When undefined, target bits [1:0] are
// dropped and misalign_err is constant 0.
module fetch_controller #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc,
   output logic [31:0] fetch_count,
   output logic        misalign_err
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] HOLD  = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
`ifdef FETCH_MISALIGN_CHECK_EN
   localparam logic [2:0] ERROR = 3'd4;
`endif

   logic [2:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drain_addr_q, drain_addr_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [31:0] redir_target_aligned;
   logic        redir_take;

   // Targets are always word-aligned once they reach pc.
   assign redir_target_aligned = {redirect_target[31:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;
   logic redir_misaligned;

   assign redir_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
   // A misaligned redirect never updates pc; it diverts to ERROR instead.
   assign redir_take       = redirect_valid && !redir_misaligned;
`else
   logic unused_target_lsbs;

   // Low target bits are intentionally discarded in this build.
   assign unused_target_lsbs = ^redirect_target[1:0];
   assign redir_take         = redirect_valid;
`endif

   // Next-state and datapath decisions for the fetch sequencer.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      drain_addr_d  = drain_addr_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      fetch_count_d = fetch_count_q;
`ifdef FETCH_MISALIGN_CHECK_EN
      misalign_d    = misalign_q;
`endif
      case (state_q)
         IDLE: begin
            state_d = FETCH;
         end
         FETCH: begin
            if (redir_take) begin
               pc_d = redir_target_aligned;
               if (!imem_ready) begin
                  // Request already on the bus must complete at its old address.
                  drain_addr_d = pc_q;
                  state_d      = DRAIN;
               end else begin
                  // Returned word belongs to the old path: drop it, refetch.
                  state_d = FETCH;
               end
            end else if (imem_ready) begin
               instr_d       = imem_rdata;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            if (redir_take) begin
               // Redirect beats stall; the held instruction is not counted.
               pc_d          = redir_target_aligned;
               instr_valid_d = 1'b0;
               state_d       = FETCH;
            end else if (!stall) begin
               pc_d          = pc_q + 32'd4;
               fetch_count_d = fetch_count_q + 32'd1;
               instr_valid_d = 1'b0;
               state_d       = FETCH;
            end
         end
         DRAIN: begin
            // Newest redirect target always wins; the outstanding request
            // still finishes at drain_addr_q before fetching resumes.
            if (redir_take) begin
               pc_d = redir_target_aligned;
            end
            if (imem_ready) begin
               state_d = FETCH;
            end
         end
`ifdef FETCH_MISALIGN_CHECK_EN
         ERROR: begin
            instr_valid_d = 1'b0;
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      // Misaligned redirect from any active state overrides everything above.
      if (redir_misaligned &&
          (state_q == FETCH || state_q == HOLD || state_q == DRAIN)) begin
         state_d       = ERROR;
         misalign_d    = 1'b1;
         instr_valid_d = 1'b0;
         pc_d          = pc_q;
         drain_addr_d  = drain_addr_q;
      end
`endif
   end

   // State and architectural registers, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         pc_q          <= RESET_VECTOR;
         instr_q       <= 32'd0;
         instr_pc_q    <= 32'd0;
         instr_valid_q <= 1'b0;
         fetch_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   // Old request address only matters while in DRAIN, so it needs no reset.
   always_ff @(posedge clk) begin
      drain_addr_q <= drain_addr_d;
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   // Sticky misalignment flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end

   assign misalign_err = misalign_q;
`else
   assign misalign_err = 1'b0;
`endif

   // Memory request is a pure decode of state; DRAIN replays the old address.
   assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
   assign imem_addr   = (state_q == DRAIN) ? drain_addr_q : pc_q;

   assign instr_valid = instr_valid_q;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign pc          = pc_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_fetch_controller;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc;
   logic [31:0] fetch_count;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   // Reference model: abstract fetch status rather than FSM states.
   bit          m_started;   // left the post-reset idle cycle
   bit          m_holding;   // an instruction is presented to the core
   bit          m_draining;  // a stale request is still waiting on memory
   bit          m_err;       // parked after a misaligned redirect
   logic [31:0] m_pc, m_stale_addr, m_instr, m_ipc, m_cnt;
   logic        m_mis;

   logic [31:0] sv_instr, sv_ipc, sv_pc;

   fetch_controller dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .instr_valid     (instr_valid),
      .instr           (instr),
      .instr_pc        (instr_pc),
      .pc              (pc),
      .fetch_count     (fetch_count),
      .misalign_err    (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs the DUT just sampled.
   task automatic model_step();
      logic [31:0] tgt;
      bit          mis;
      tgt = {redirect_target[31:2], 2'b00};
      mis = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      mis = (redirect_target[1:0] != 2'b00);
`endif
      if (reset) begin
         m_started = 0; m_holding = 0; m_draining = 0; m_err = 0;
         m_pc = 32'h0000_1000; m_instr = 0; m_ipc = 0; m_cnt = 0; m_mis = 1'b0;
      end else if (!m_started) begin
         m_started = 1;
      end else if (m_err) begin
         // parked until reset
      end else if (redirect_valid && mis) begin
         m_err = 1; m_mis = 1'b1; m_holding = 0; m_draining = 0;
      end else if (redirect_valid) begin
         if (m_holding) begin
            m_holding = 0;
         end else if (m_draining) begin
            if (imem_ready) m_draining = 0;
         end else if (!imem_ready) begin
            m_draining = 1;
            m_stale_addr = m_pc;
         end
         m_pc = tgt;
      end else if (m_holding) begin
         if (!stall) begin
            m_holding = 0;
            m_pc = m_pc + 32'd4;
            m_cnt = m_cnt + 32'd1;
         end
      end else if (m_draining) begin
         if (imem_ready) m_draining = 0;
      end else if (imem_ready) begin
         m_holding = 1;
         m_instr = imem_rdata;
         m_ipc = m_pc;
      end
   endtask

   task automatic check_model();
      logic exp_req;
      exp_req = m_started && !m_holding && !m_err;
      chk("m_req", imem_req, exp_req);
      if (exp_req) chk("m_addr", imem_addr, m_draining ? m_stale_addr : m_pc);
      chk("m_ivalid", instr_valid, m_holding);
      chk("m_instr", instr, m_instr);
      chk("m_ipc", instr_pc, m_ipc);
      chk("m_pc", pc, m_pc);
      chk("m_cnt", fetch_count, m_cnt);
      chk("m_mis", misalign_err, m_mis);
   endtask

   task automatic drive(input logic r, input logic st, input logic rv,
                        input logic [31:0] rt, input logic rdy);
      reset = r; stall = st; redirect_valid = rv; redirect_target = rt;
      imem_ready = rdy; imem_rdata = $urandom;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_req"}, imem_req, 0);
      chk({tag, "_ivalid"}, instr_valid, 0);
      chk({tag, "_instr"}, instr, 0);
      chk({tag, "_ipc"}, instr_pc, 0);
      chk({tag, "_pc"}, pc, 32'h0000_1000);
      chk({tag, "_cnt"}, fetch_count, 0);
      chk({tag, "_mis"}, misalign_err, 0);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0);
      tick();
      tick();
      check_reset_values("rst");

      // Sequential fetch with zero-wait memory: a new request every other cycle.
      drive(0, 0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("seq_req", imem_req, 1);
         chk("seq_addr", imem_addr, 32'h0000_1000 + 32'(4 * k));
         drive(0, 0, 0, 0, 1);
         tick();
         chk("seq_hold", instr_valid, 1);
         chk("seq_ipc", instr_pc, 32'h0000_1000 + 32'(4 * k));
         drive(0, 0, 0, 0, 1);
      end
      tick();
      chk("seq_cnt3", fetch_count, 3);
      chk("seq_next", imem_addr, 32'h0000_100C);

      // Stall in HOLD for five cycles: everything frozen.
      drive(0, 0, 0, 0, 1);
      tick();
      sv_instr = instr; sv_ipc = instr_pc; sv_pc = pc;
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 0, 0, 1'($urandom));
         tick();
         chk("stall_instr", instr, sv_instr);
         chk("stall_ipc", instr_pc, sv_ipc);
         chk("stall_ivalid", instr_valid, 1);
         chk("stall_req", imem_req, 0);
         chk("stall_pc", pc, sv_pc);
      end

      // Redirect in HOLD while stalled: held instruction dropped.
      drive(0, 1, 1, 32'h0000_3000, 0);
      tick();
      chk("rh_ivalid", instr_valid, 0);
      chk("rh_addr", imem_addr, 32'h0000_3000);
      chk("rh_cnt", fetch_count, 3);

      // Redirect in FETCH with memory not ready: old address drained.
      drive(0, 0, 1, 32'h0000_2000, 0);
      tick();
      chk("dr_req0", imem_req, 1);
      chk("dr_addr0", imem_addr, 32'h0000_3000);
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 0, 0, 0);
         tick();
         chk("dr_addr", imem_addr, 32'h0000_3000);
         chk("dr_ivalid", instr_valid, 0);
      end
      drive(0, 0, 0, 0, 1);
      tick();
      chk("dr_new_addr", imem_addr, 32'h0000_2000);
      chk("dr_no_instr", instr_valid, 0);

      // PC wrap-around at the top of the address space.
      drive(0, 0, 1, 32'hFFFF_FFFC, 1);
      tick();
      chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0, 1);
      tick();
      chk("wr_ipc", instr_pc, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0, 1);
      tick();
      chk("wr_addr0", imem_addr, 32'h0000_0000);
      chk("wr_cnt", fetch_count, 4);

      // Reset while draining.
      drive(0, 0, 1, 32'h0000_4000, 0);
      tick();
      chk("rd_req", imem_req, 1);
      chk("rd_addr", imem_addr, 32'h0000_0000);
      drive(1, 0, 0, 0, 0);
      tick();
      check_reset_values("rd");

      // Misaligned redirect.
      drive(0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 1, 32'h0000_2002, 1);
      tick();
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("mis_flag", misalign_err, 1);
      chk("mis_req", imem_req, 0);
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 1'($urandom), $urandom & 32'hFFFF_FFFC, 1);
         tick();
         chk("mis_park_req", imem_req, 0);
         chk("mis_park_flag", misalign_err, 1);
      end
`else
      chk("mis_req", imem_req, 1);
      chk("mis_addr", imem_addr, 32'h0000_2000);
      chk("mis_flag", misalign_err, 0);
`endif

      // Randomized traffic against the model.
      drive(1, 0, 0, 0, 0);
      tick();
      for (int n = 0; n < 600; n++) begin
         logic [31:0] t;
         t = $urandom;
         if ($urandom_range(3) != 0) t[1:0] = 2'b00;
         drive($urandom_range(99) == 0, 1'($urandom), $urandom_range(5) == 0, t,
               $urandom_range(9) < 6);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
